// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline sequencer: flag register, stalls, flush refill, retire count
module pipe_ctrl #(
    parameter int          REFILL   = 1,
    parameter logic [3:0]  FLAG_RST = 4'b0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        ex_valid,
    input  logic        alu_s,
    input  logic        alu_z,
    input  logic        alu_c,
    input  logic        alu_v,
    input  logic        alu_hlt,
    input  logic        alu_flush,
    input  logic        ld_use,
    output logic        flag_s,
    output logic        flag_z,
    output logic        flag_c,
    output logic        flag_v,
    output logic        pc_we,
    output logic        pc_sel,
    output logic        if_id_we,
    output logic        id_ex_we,
    output logic        if_id_clr,
    output logic        id_ex_clr,
    output logic        running,
    output logic        halted,
    output logic [15:0] retired
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_HALT} state_t;

    localparam logic [2:0] CNT_INIT = (REFILL > 0) ? 3'(REFILL - 1) : 3'd0;

    state_t      r_state;
    logic [2:0]  r_cnt;
    logic [3:0]  r_flags;
    logic [15:0] r_retired;
    logic        r_running;
    logic        r_halted;

    logic        w_hlt;
    logic        w_flush;
    logic [3:0]  w_alu_flags;

    assign w_hlt       = ex_valid & alu_hlt;
    assign w_flush     = ex_valid & alu_flush;
    assign w_alu_flags = {alu_s, alu_z, alu_c, alu_v};

    assign {flag_s, flag_z, flag_c, flag_v} = r_flags;
    assign retired = r_retired;
    assign running = r_running;
    assign halted  = r_halted;

    // Clears win over enables downstream, so a cleared stage's we value is irrelevant.
    always_comb begin
        pc_we     = 1'b0;
        pc_sel    = 1'b0;
        if_id_we  = 1'b0;
        id_ex_we  = 1'b0;
        if_id_clr = 1'b0;
        id_ex_clr = 1'b0;
        case (r_state)
            S_IDLE: begin
                if_id_clr = 1'b1;
                id_ex_clr = 1'b1;
            end
            S_RUN: begin
                if (w_hlt) begin
                    if_id_clr = 1'b1;
                    id_ex_clr = 1'b1;
                end else if (w_flush) begin
                    pc_we     = 1'b1;
                    pc_sel    = 1'b1;
                    if_id_clr = 1'b1;
                    id_ex_clr = 1'b1;
                end else if (ld_use) begin
                    id_ex_clr = 1'b1;
                end else begin
                    pc_we    = 1'b1;
                    if_id_we = 1'b1;
                    id_ex_we = 1'b1;
                end
            end
            S_FLUSH: begin
                pc_we     = 1'b1;
                if_id_clr = 1'b1;
                id_ex_we  = 1'b1;
            end
            S_HALT: begin
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= 3'd0;
            r_flags   <= FLAG_RST;
            r_retired <= 16'd0;
            r_running <= 1'b0;
            r_halted  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state   <= S_RUN;
                        r_running <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_hlt) begin
                        r_retired <= r_retired + 16'd1;
                        r_state   <= S_HALT;
                        r_running <= 1'b0;
                        r_halted  <= 1'b1;
                    end else if (w_flush) begin
                        r_flags   <= w_alu_flags;
                        r_retired <= r_retired + 16'd1;
                        if (REFILL != 0) begin
                            r_state <= S_FLUSH;
                            r_cnt   <= CNT_INIT;
                        end
                    end else if (ex_valid) begin
                        r_flags   <= w_alu_flags;
                        r_retired <= r_retired + 16'd1;
                    end
                end
                S_FLUSH: begin
                    // EX holds a fetch bubble here; its control indications are stale.
                    if (r_cnt == 3'd0) begin
                        r_state <= S_RUN;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                S_HALT: begin
                    if (start) begin
                        r_state   <= S_RUN;
                        r_running <= 1'b1;
                        r_halted  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - scenario and randomized bench for pipe_ctrl against a mode-level model
module tb_pipe_ctrl;
    localparam int REFILL = 2;

    logic clk = 1'b0;
    logic rst, start, ex_valid, alu_s, alu_z, alu_c, alu_v, alu_hlt, alu_flush, ld_use;
    logic flag_s, flag_z, flag_c, flag_v, pc_we, pc_sel, if_id_we, id_ex_we;
    logic if_id_clr, id_ex_clr, running, halted;
    logic [15:0] retired;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: mode 0 idle, 1 run, 2 refill bubbles, 3 halted
    int         m_mode = 0;
    int         m_bubbles = 0;
    int         m_retired = 0;
    logic [3:0] m_flags = 4'b0000;
    logic [7:0] g_exp, g_care, g_got;

    pipe_ctrl #(.REFILL(REFILL), .FLAG_RST(4'b0000)) dut (
        .clk(clk), .rst(rst), .start(start), .ex_valid(ex_valid),
        .alu_s(alu_s), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
        .alu_hlt(alu_hlt), .alu_flush(alu_flush), .ld_use(ld_use),
        .flag_s(flag_s), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v),
        .pc_we(pc_we), .pc_sel(pc_sel), .if_id_we(if_id_we), .id_ex_we(id_ex_we),
        .if_id_clr(if_id_clr), .id_ex_clr(id_ex_clr), .running(running),
        .halted(halted), .retired(retired)
    );

    always #5 clk = ~clk;

    // Drive inputs mid-cycle and derive expected controls {pc_we,pc_sel,if_id_we,id_ex_we,if_id_clr,id_ex_clr,running,halted}
    task automatic apply(input logic r, input logic st, input logic ev, input logic h,
                         input logic f, input logic lu, input logic [3:0] fl);
        rst = r; start = st; ex_valid = ev; alu_hlt = h; alu_flush = f; ld_use = lu;
        {alu_s, alu_z, alu_c, alu_v} = fl;
        #1;
        g_got = {pc_we, pc_sel, if_id_we, id_ex_we, if_id_clr, id_ex_clr, running, halted};
        case (m_mode)
            0: begin g_exp = 8'b0000_1100; g_care = 8'b1011_1111; end
            1: begin
                if (ev && h)      begin g_exp = 8'b0000_1110; g_care = 8'b1011_1111; end
                else if (ev && f) begin g_exp = 8'b1100_1110; g_care = 8'b1100_1111; end
                else if (lu)      begin g_exp = 8'b0000_0110; g_care = 8'b1010_0111; end
                else              begin g_exp = 8'b1011_0010; g_care = 8'b1111_1111; end
            end
            2: begin g_exp = 8'b1001_1010; g_care = 8'b1101_1011; end
            default: begin g_exp = 8'b0000_0001; g_care = 8'b1011_1111; end
        endcase
    endtask

    task automatic tick();
        if (rst) begin
            m_mode = 0; m_flags = 4'b0000; m_retired = 0; m_bubbles = 0;
        end else begin
            case (m_mode)
                0: if (start) m_mode = 1;
                1: begin
                    if (ex_valid && alu_hlt) begin
                        m_retired = (m_retired + 1) % 65536;
                        m_mode = 3;
                    end else if (ex_valid && alu_flush) begin
                        m_flags = {alu_s, alu_z, alu_c, alu_v};
                        m_retired = (m_retired + 1) % 65536;
                        if (REFILL > 0) begin m_mode = 2; m_bubbles = REFILL; end
                    end else if (ex_valid) begin
                        m_flags = {alu_s, alu_z, alu_c, alu_v};
                        m_retired = (m_retired + 1) % 65536;
                    end
                end
                2: begin
                    m_bubbles = m_bubbles - 1;
                    if (m_bubbles == 0) m_mode = 1;
                end
                default: if (start) m_mode = 1;
            endcase
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        apply(1, 0, 0, 0, 0, 0, 4'b0000); tick();
        apply(1, 0, 0, 0, 0, 0, 4'b0000); tick();
        apply(0, 0, 0, 0, 0, 0, 4'b0000);
        n_tests++;
        if ({flag_s, flag_z, flag_c, flag_v} !== 4'b0000 || retired !== 16'd0 ||
            if_id_clr !== 1'b1 || id_ex_clr !== 1'b1 || running !== 1'b0 || pc_we !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle flags=%b retired=%h clr=%b%b run=%b pc_we=%b, want 0000 0000 11 0 0",
                     {flag_s, flag_z, flag_c, flag_v}, retired, if_id_clr, id_ex_clr, running, pc_we);
        end
        tick();
        apply(0, 1, 0, 0, 0, 0, 4'b0000); tick();
        apply(0, 0, 0, 0, 0, 0, 4'b0000);
        n_tests++;
        if (running !== 1'b1 || pc_we !== 1'b1) begin
            n_fail++;
            $display("FAIL start_run running=%b pc_we=%b, want 1 1", running, pc_we);
        end
        tick();
    endtask

    task automatic test_flags();
        for (int i = 0; i < 5; i++) begin
            apply(0, 0, 1, 0, 0, 0, (i >= 2) ? 4'b1001 : 4'b0000);
            n_tests++;
            if ((g_got & g_care) !== (g_exp & g_care) || {flag_s, flag_z, flag_c, flag_v} !== m_flags) begin
                n_fail++;
                $display("FAIL flags_op%0d ctrl=%b flags=%b, want ctrl=%b flags=%b",
                         i, g_got & g_care, {flag_s, flag_z, flag_c, flag_v}, g_exp & g_care, m_flags);
            end
            if (i >= 3) begin
                n_tests++;
                if ({flag_s, flag_z, flag_c, flag_v} !== 4'b1001) begin
                    n_fail++;
                    $display("FAIL flags_after_op3 got=%b want=1001", {flag_s, flag_z, flag_c, flag_v});
                end
            end
            tick();
        end
        apply(0, 0, 0, 0, 0, 0, 4'b0000);
        n_tests++;
        if (retired !== 16'd5 || {flag_s, flag_z, flag_c, flag_v} !== 4'b1001) begin
            n_fail++;
            $display("FAIL retire_five retired=%0d flags=%b, want 5 1001", retired, {flag_s, flag_z, flag_c, flag_v});
        end
        tick();
    endtask

    task automatic test_flush();
        int r0;
        r0 = m_retired;
        apply(0, 0, 1, 0, 1, 0, 4'b0110);
        n_tests++;
        if (pc_sel !== 1'b1 || pc_we !== 1'b1 || if_id_clr !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_redirect pc_sel=%b pc_we=%b if_id_clr=%b, want 1 1 1", pc_sel, pc_we, if_id_clr);
        end
        tick();
        for (int i = 0; i < REFILL; i++) begin
            apply(0, 0, 1, 1, 1, 1, 4'b1111);
            n_tests++;
            if (if_id_clr !== 1'b1 || running !== 1'b1 || halted !== 1'b0 || pc_sel !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_refill%0d if_id_clr=%b running=%b halted=%b pc_sel=%b, want 1 1 0 0",
                         i, if_id_clr, running, halted, pc_sel);
            end
            tick();
        end
        apply(0, 0, 0, 0, 0, 0, 4'b0000);
        n_tests++;
        if (running !== 1'b1 || halted !== 1'b0 || if_id_clr !== 1'b0 ||
            retired !== 16'(r0 + 1) || {flag_s, flag_z, flag_c, flag_v} !== 4'b0110) begin
            n_fail++;
            $display("FAIL flush_done running=%b halted=%b if_id_clr=%b retired=%0d flags=%b, want 1 0 0 %0d 0110",
                     running, halted, if_id_clr, retired, {flag_s, flag_z, flag_c, flag_v}, r0 + 1);
        end
        tick();
    endtask

    task automatic test_halt();
        logic [3:0] fb;
        fb = m_flags;
        apply(0, 0, 1, 1, 1, 0, ~fb);
        n_tests++;
        if (pc_we !== 1'b0 || if_id_we !== 1'b0 || id_ex_we !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_cycle pc_we=%b if_id_we=%b id_ex_we=%b, want 0 0 0", pc_we, if_id_we, id_ex_we);
        end
        tick();
        apply(0, 0, 1, 0, 0, 0, ~fb);
        n_tests++;
        if (halted !== 1'b1 || running !== 1'b0 || pc_we !== 1'b0 || {flag_s, flag_z, flag_c, flag_v} !== fb) begin
            n_fail++;
            $display("FAIL halt_state halted=%b running=%b pc_we=%b flags=%b, want 1 0 0 %b",
                     halted, running, pc_we, {flag_s, flag_z, flag_c, flag_v}, fb);
        end
        tick();
        apply(0, 1, 0, 0, 0, 0, 4'b0000); tick();
        apply(0, 0, 0, 0, 0, 0, 4'b0000);
        n_tests++;
        if (running !== 1'b1 || halted !== 1'b0 || {flag_s, flag_z, flag_c, flag_v} !== fb) begin
            n_fail++;
            $display("FAIL halt_resume running=%b halted=%b flags=%b, want 1 0 %b",
                     running, halted, {flag_s, flag_z, flag_c, flag_v}, fb);
        end
        tick();
    endtask

    task automatic test_ld_use();
        for (int i = 0; i < 2; i++) begin
            apply(0, 0, 1, 0, 0, 1, 4'($urandom));
            n_tests++;
            if (pc_we !== 1'b0 || if_id_we !== 1'b0 || id_ex_clr !== 1'b1) begin
                n_fail++;
                $display("FAIL ld_use_stall%0d pc_we=%b if_id_we=%b id_ex_clr=%b, want 0 0 1",
                         i, pc_we, if_id_we, id_ex_clr);
            end
            tick();
        end
        apply(0, 0, 1, 0, 0, 0, 4'($urandom));
        n_tests++;
        if ({pc_we, if_id_we, id_ex_we, if_id_clr, id_ex_clr} !== 5'b11100) begin
            n_fail++;
            $display("FAIL ld_use_release we/clr=%b want 11100", {pc_we, if_id_we, id_ex_we, if_id_clr, id_ex_clr});
        end
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            apply($urandom_range(0, 59) == 0, $urandom_range(0, 7) == 0, 1'($urandom),
                  $urandom_range(0, 15) == 0, $urandom_range(0, 6) == 0,
                  $urandom_range(0, 5) == 0, 4'($urandom));
            n_tests++;
            if ((g_got & g_care) !== (g_exp & g_care) || {flag_s, flag_z, flag_c, flag_v} !== m_flags ||
                retired !== 16'(m_retired)) begin
                n_fail++;
                $display("FAIL random%0d ctrl=%b flags=%b retired=%0d, want ctrl=%b flags=%b retired=%0d",
                         i, g_got & g_care, {flag_s, flag_z, flag_c, flag_v}, retired,
                         g_exp & g_care, m_flags, m_retired);
            end
            tick();
        end
    endtask

    task automatic test_rst_flush();
        apply(1, 0, 0, 0, 0, 0, 4'b0000); tick();
        apply(0, 1, 0, 0, 0, 0, 4'b0000); tick();
        apply(0, 0, 1, 0, 1, 0, 4'b0011); tick();
        apply(1, 0, 0, 0, 0, 0, 4'b0000); tick();
        apply(0, 0, 0, 0, 0, 0, 4'b0000);
        n_tests++;
        if (running !== 1'b0 || halted !== 1'b0 || pc_we !== 1'b0 || if_id_clr !== 1'b1 ||
            id_ex_clr !== 1'b1 || {flag_s, flag_z, flag_c, flag_v} !== 4'b0000 || retired !== 16'd0) begin
            n_fail++;
            $display("FAIL rst_mid_flush running=%b pc_we=%b clr=%b%b flags=%b retired=%0d, want 0 0 11 0000 0",
                     running, pc_we, if_id_clr, id_ex_clr, {flag_s, flag_z, flag_c, flag_v}, retired);
        end
        tick();
        apply(0, 1, 0, 0, 0, 0, 4'b0000); tick();
        apply(0, 0, 1, 0, 1, 0, 4'b0101); tick();
        for (int i = 0; i < REFILL + 2; i++) begin
            apply(0, 0, 1, 0, 0, 0, 4'b0101);
            n_tests++;
            if ((g_got & g_care) !== (g_exp & g_care) || retired !== 16'(m_retired)) begin
                n_fail++;
                $display("FAIL refill_after_rst%0d ctrl=%b retired=%0d, want ctrl=%b retired=%0d",
                         i, g_got & g_care, retired, g_exp & g_care, m_retired);
            end
            tick();
        end
    endtask

    task automatic test_wrap();
        apply(1, 0, 0, 0, 0, 0, 4'b0000); tick();
        apply(0, 1, 0, 0, 0, 0, 4'b0000); tick();
        while (m_retired != 65535) begin
            apply(0, 0, 1, 0, 0, 0, 4'b0000); tick();
        end
        apply(0, 0, 0, 0, 0, 0, 4'b0000);
        n_tests++;
        if (retired !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL retire_max retired=%h want FFFF", retired);
        end
        tick();
        apply(0, 0, 1, 0, 0, 0, 4'b0000); tick();
        apply(0, 0, 0, 0, 0, 0, 4'b0000);
        n_tests++;
        if (retired !== 16'h0000) begin
            n_fail++;
            $display("FAIL retire_wrap retired=%h want 0000", retired);
        end
        tick();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; ex_valid = 1'b0; alu_hlt = 1'b0; alu_flush = 1'b0; ld_use = 1'b0;
        {alu_s, alu_z, alu_c, alu_v} = 4'b0000;
        @(negedge clk);
        test_reset();
        test_flags();
        test_flush();
        test_halt();
        test_ld_use();
        test_random();
        test_rst_flush();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
